// File: rtl/mrc_sched_pkg.sv
// Shared types and default sizing for the MRC pipe scheduler.
package mrc_sched_pkg;

  localparam int MRC_PAYLOAD_W = 110;
  localparam int MRC_RES_W     = 32;
  // Must equal the summed stage latency of the MRC pipe instance.
  localparam int MRC_PIPE_LAT  = 40;
  localparam int MRC_NREQ      = 4;
  localparam int MRC_MAX_OUTST = 8;
  localparam int MRC_ID_W      = 3;

  typedef struct packed {
    logic                v;
    logic [MRC_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/mrc_tag_delay.sv
// Delay line for requester tags, matched to the MRC pipe latency so each
// tag reaches the tail in the same cycle as its result.
module mrc_tag_delay
  import mrc_sched_pkg::*;
#(
  parameter int DEPTH = MRC_PIPE_LAT + 1
) (
  input  logic clk,
  input  logic reset_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t line [DEPTH];

  // NOTE: every stage is cleared on reset, not just the head; a stale valid
  // bit left in the line would retire an operation that no longer exists.
  // NOTE: non-blocking assignments let each stage take its neighbour's
  // pre-edge value, independent of statement order in the loop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign tag_out = line[DEPTH-1];

endmodule

// File: rtl/mrc_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency MRC pipe between NREQ
// requesters, with per-requester credits and flush/drain sequencing.
// Optional MRC_SCHED_PERF_EN adds perf_issue / perf_stall counters.
module mrc_pipe_sched
  import mrc_sched_pkg::*;
#(
  parameter int NREQ      = MRC_NREQ,
  parameter int PAYLOAD_W = MRC_PAYLOAD_W,
  parameter int RES_W     = MRC_RES_W,
  parameter int PIPE_LAT  = MRC_PIPE_LAT,
  parameter int MAX_OUTST = MRC_MAX_OUTST
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*PAYLOAD_W-1:0] req_data,
  output logic                      pipe_in_valid,
  output logic [PAYLOAD_W-1:0]      pipe_in_data,
  input  logic [RES_W-1:0]          pipe_out_data,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [RES_W-1:0]          rsp_data,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      busy
`ifdef MRC_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_issue,
  output logic [31:0]               perf_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  sched_state_t          state, state_nxt;
  logic [CNT_W-1:0]      outst [NREQ];
  logic [MRC_ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       retire;
  logic                  xfer;
  logic [MRC_ID_W-1:0]   win;
  logic [PAYLOAD_W-1:0]  win_data;
  logic [MRC_ID_W-1:0]   issue_id;
  tag_t                  tag_in;
  tag_t                  tag_tail;

  // Requests are not granted while reset is asserted or the pipe is draining.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = reset_n && req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST)) && (state != DRAIN);
    end
  end

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  // First pass searches rr_ptr..NREQ-1, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    grant    = '0;
    win      = '0;
    xfer     = 1'b0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!xfer && elig[i] && (i >= int'(rr_ptr))) begin
        grant[i] = 1'b1;
        win      = MRC_ID_W'(i);
        xfer     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!xfer && elig[i]) begin
        grant[i] = 1'b1;
        win      = MRC_ID_W'(i);
        xfer     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_data = req_data[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_in_valid <= 1'b0;
      pipe_in_data  <= '0;
      issue_id      <= '0;
    end else begin
      pipe_in_valid <= xfer;
      if (xfer) begin
        pipe_in_data <= win_data;
        issue_id     <= win;
      end
    end
  end

  // The tag enters alongside the issue strobe; with PIPE_LAT+1 stages the
  // response registers fire PIPE_LAT+2 clocks after the accept.
  assign tag_in = '{v: pipe_in_valid, id: issue_id};

  mrc_tag_delay #(
    .DEPTH (PIPE_LAT + 1)
  ) u_tag_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      retire[i] = tag_tail.v && (tag_tail.id == MRC_ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= retire;
      if (tag_tail.v) rsp_data <= pipe_out_data;
    end
  end

  // A simultaneous issue and retire for one requester leaves its count as is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant[i], retire[i]})
          2'b10:   outst[i] <= outst[i] + 1'b1;
          2'b01:   if (outst[i] != '0) outst[i] <= outst[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (outst[i] != '0) busy = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req)       state_nxt = DRAIN;
        else if (|req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (flush_req)                  state_nxt = DRAIN;
        else if (!(|req_valid) && !busy) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!busy) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MRC_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (xfer && (perf_issue != 32'hFFFF_FFFF)) perf_issue <= perf_issue + 32'd1;
      if ((|req_valid) && !xfer && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mrc_pipe_sched.sv
// Self-checking bench for mrc_pipe_sched: a behavioural MRC pipe feeds
// results back and a scoreboard matches every response to its accept.
module tb_mrc_pipe_sched;

  localparam int NREQ    = 4;
  localparam int PW      = 110;
  localparam int RW      = 32;
  localparam int LAT     = 40;
  localparam int RSP_LAT = LAT + 2;

  typedef struct {
    logic [2:0]    id;
    logic [PW-1:0] pay;
    int            acc;
  } exp_t;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*PW-1:0]   req_data;
  logic                 pipe_in_valid;
  logic [PW-1:0]        pipe_in_data;
  logic [RW-1:0]        pipe_out_data;
  logic [NREQ-1:0]      rsp_valid;
  logic [RW-1:0]        rsp_data;
  logic                 flush_req;
  logic                 flush_done;
  logic                 busy;
`ifdef MRC_SCHED_PERF_EN
  logic [31:0]          perf_issue;
  logic [31:0]          perf_stall;
`endif

  logic [PW-1:0] pay [NREQ];
  exp_t          sb [$];
  exp_t          mon_e;
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  logic [2:0]    last_win = 3'(NREQ - 1);

  logic [PW-1:0] pq_d [LAT+1];
  logic          pq_v [LAT+1];

  mrc_pipe_sched dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .pipe_in_valid (pipe_in_valid),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_data (pipe_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .busy          (busy)
`ifdef MRC_SCHED_PERF_EN
    ,
    .perf_issue    (perf_issue),
    .perf_stall    (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] mrc_model(input logic [PW-1:0] p);
    return p[31:0] ^ p[63:32] ^ p[95:64] ^ {18'h0, p[109:96]} ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[i*PW +: PW] = pay[i];
  end

  // Stand-in MRC pipe: its result is presented in the cycle the matching tag
  // reaches the tail of the scheduler's delay line.
  always @(posedge clk) begin
    pq_d[0] <= pipe_in_data;
    pq_v[0] <= pipe_in_valid;
    for (int i = 1; i <= LAT; i++) begin
      pq_d[i] <= pq_d[i-1];
      pq_v[i] <= pq_v[i-1];
    end
  end
  assign pipe_out_data = (pq_v[LAT] === 1'b1) ? mrc_model(pq_d[LAT]) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rsp_valid !== '0) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL rsp_unexpected rsp_valid=%b required none", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid === (4'b0001 << mon_e.id) && rsp_data === mrc_model(mon_e.pay) &&
            (cyc - mon_e.acc) == RSP_LAT)
          n_pass++;
        else
          $display("FAIL rsp_match valid=%b/%b data=%h/%h latency=%0d/%0d", rsp_valid,
                   4'b0001 << mon_e.id, rsp_data, mrc_model(mon_e.pay), cyc - mon_e.acc, RSP_LAT);
      end
    end
  end

  // One clock of stimulus: records the transfer the coming edge will make.
  task automatic tick(output logic got, output logic [2:0] gid, output int acc);
    logic [NREQ-1:0] x;
    #1;
    x   = req_valid & req_ready;
    got = |x;
    gid = '0;
    acc = cyc + 1;
    for (int i = 0; i < NREQ; i++) if (x[i]) gid = 3'(i);
    n_total++;
    if ($onehot0(req_ready)) n_pass++;
    else $display("FAIL ready_onehot req_ready=%b required at most one bit", req_ready);
    if (got) begin
      sb.push_back(exp_t'{id: gid, pay: pay[gid], acc: acc});
      last_win = gid;
    end
    @(posedge clk);
    @(negedge clk);
    if (got) pay[gid] = rand_payload();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && busy === 1'b0)) begin
      @(negedge clk);
      #2;
      n++;
    end
    n_total++;
    if (sb.size() == 0 && busy === 1'b0) n_pass++;
    else $display("FAIL drain_timeout pending=%0d busy=%b required 0 and 0", sb.size(), busy);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    flush_req = 1'b0;
    for (int i = 0; i < NREQ; i++) pay[i] = rand_payload();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++; if (req_ready === '0) n_pass++; else $display("FAIL reset_ready got %b want 0", req_ready);
    n_total++; if (pipe_in_valid === 1'b0) n_pass++; else $display("FAIL reset_pipe_valid got %b want 0", pipe_in_valid);
    n_total++; if (pipe_in_data === '0) n_pass++; else $display("FAIL reset_pipe_data got %h want 0", pipe_in_data);
    n_total++; if (rsp_valid === '0) n_pass++; else $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    n_total++; if (rsp_data === '0) n_pass++; else $display("FAIL reset_rsp_data got %h want 0", rsp_data);
    n_total++; if (flush_done === 1'b0) n_pass++; else $display("FAIL reset_flush_done got %b want 0", flush_done);
    n_total++; if (busy === 1'b0) n_pass++; else $display("FAIL reset_busy got %b want 0", busy);
  endtask

  task automatic test_single();
    logic got; logic [2:0] gid; int acc;
    logic [PW-1:0] p;
    p = pay[1];
    req_valid = 4'b0010;
    tick(got, gid, acc);
    req_valid = '0;
    #1;
    n_total++; if (got === 1'b1 && gid === 3'd1) n_pass++;
    else $display("FAIL single_grant got=%b id=%0d required 1 and 1", got, gid);
    n_total++; if (pipe_in_valid === 1'b1) n_pass++;
    else $display("FAIL single_issue_valid got %b want 1", pipe_in_valid);
    n_total++; if (pipe_in_data === p) n_pass++;
    else $display("FAIL single_issue_data got %h want %h", pipe_in_data, p);
    wait_drain(60);
  endtask

  task automatic test_round_robin();
    logic got; logic [2:0] gid; int acc;
    logic [2:0] exp_id;
    int ops = 0, bad = 0, cycles = 0;
    req_valid = '1;
    while (ops < 1000 && cycles < 5000) begin
      exp_id = 3'((int'(last_win) + 1) % NREQ);
      tick(got, gid, acc);
      cycles++;
      if (got) begin
        ops++;
        if (gid !== exp_id) bad++;
      end
    end
    req_valid = '0;
    n_total++; if (bad == 0 && ops == 1000) n_pass++;
    else $display("FAIL rr_order out_of_order=%0d ops=%0d required 0 and 1000", bad, ops);
    wait_drain(200);
  endtask

  task automatic test_credit_limit();
    logic got; logic [2:0] gid; int acc;
    int acc0 = 0, n_acc = 0, n = 0;
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick(got, gid, acc);
      if (i == 0) acc0 = acc;
      if (got) n_acc++;
    end
    n_total++; if (n_acc == 8) n_pass++;
    else $display("FAIL credit_accepts got %0d want 8", n_acc);
    #1;
    n_total++; if (req_ready[0] === 1'b0) n_pass++;
    else $display("FAIL credit_block req_ready[0]=%b want 0", req_ready[0]);
    got = 1'b0;
    while (!got && n < 100) begin
      tick(got, gid, acc);
      n++;
    end
    n_total++; if (got === 1'b1 && acc == acc0 + RSP_LAT + 1) n_pass++;
    else $display("FAIL credit_resume cycle=%0d want %0d", acc - acc0, RSP_LAT + 1);
    req_valid = '0;
    wait_drain(200);
  endtask

  task automatic test_flush();
    logic got; logic [2:0] gid; int acc;
    int n_acc = 0, grants = 0, early = 0, waited = 0;
    logic seen = 1'b0;
    req_valid = 4'b0001;
    repeat (5) begin
      tick(got, gid, acc);
      if (got) n_acc++;
    end
    n_total++; if (n_acc == 5) n_pass++;
    else $display("FAIL flush_setup accepts=%0d want 5", n_acc);
    req_valid = '0;
    flush_req = 1'b1;
    tick(got, gid, acc);
    req_valid = '1;
    while (!seen && waited < 100) begin
      tick(got, gid, acc);
      waited++;
      if (got) grants++;
      #1;
      if (flush_done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) early++;
    end
    n_total++; if (seen === 1'b1) n_pass++;
    else $display("FAIL flush_done_timeout flush_done=%b want 1", flush_done);
    n_total++; if (grants == 0) n_pass++;
    else $display("FAIL flush_grants got %0d want 0", grants);
    n_total++; if (early == 0) n_pass++;
    else $display("FAIL flush_busy_early cycles=%0d want 0", early);
    n_total++; if (busy === 1'b0 && rsp_valid === 4'b0001 && sb.size() == 0) n_pass++;
    else $display("FAIL flush_last_rsp busy=%b rsp_valid=%b pending=%0d want 0 0001 0",
                  busy, rsp_valid, sb.size());
    req_valid = '0;
    flush_req = 1'b0;
    tick(got, gid, acc);
    #1;
    n_total++; if (flush_done === 1'b0) n_pass++;
    else $display("FAIL flush_pulse_width flush_done=%b want 0", flush_done);
  endtask

  task automatic test_reset_inflight();
    logic got; logic [2:0] gid; int acc;
    int n_acc = 0, spurious = 0;
    req_valid = 4'b0111;
    repeat (3) begin
      tick(got, gid, acc);
      if (got) n_acc++;
    end
    n_total++; if (n_acc == 3) n_pass++;
    else $display("FAIL rst_setup accepts=%0d want 3", n_acc);
    req_valid = '0;
    reset_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    last_win = 3'(NREQ - 1);
    #1;
    n_total++;
    if (req_ready === '0 && pipe_in_valid === 1'b0 && pipe_in_data === '0 && rsp_valid === '0 &&
        rsp_data === '0 && flush_done === 1'b0 && busy === 1'b0)
      n_pass++;
    else
      $display("FAIL rst_outputs ready=%b pv=%b rv=%b rd=%h fd=%b busy=%b want all 0",
               req_ready, pipe_in_valid, rsp_valid, rsp_data, flush_done, busy);
    repeat (50) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== '0) spurious++;
    end
    n_total++; if (spurious == 0) n_pass++;
    else $display("FAIL rst_ghost_rsp cycles=%0d want 0", spurious);
  endtask

`ifdef MRC_SCHED_PERF_EN
  task automatic test_perf();
    logic got; logic [2:0] gid; int acc;
    int n_acc = 0, blocked = 0, waited = 0;
    logic seen = 1'b0;
    req_valid = 4'b0011;
    repeat (10) begin
      tick(got, gid, acc);
      if (got) n_acc++;
    end
    req_valid = '0;
    flush_req = 1'b1;
    tick(got, gid, acc);
    req_valid = 4'b0001;
    repeat (4) begin
      tick(got, gid, acc);
      if (!got) blocked++;
    end
    req_valid = '0;
    while (!seen && waited < 100) begin
      tick(got, gid, acc);
      waited++;
      #1;
      if (flush_done === 1'b1) seen = 1'b1;
    end
    flush_req = 1'b0;
    wait_drain(60);
    n_total++; if (n_acc == 10 && blocked == 4) n_pass++;
    else $display("FAIL perf_setup accepts=%0d blocked=%0d want 10 4", n_acc, blocked);
    n_total++; if (perf_issue === 32'd10) n_pass++;
    else $display("FAIL perf_issue got %0d want 10", perf_issue);
    n_total++; if (perf_stall === 32'd4) n_pass++;
    else $display("FAIL perf_stall got %0d want 4", perf_stall);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_flush();
    test_reset_inflight();
`ifdef MRC_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
